door_blink_monitor: RTL and testbench

- Receive-side checker for the door-open blink indicator. It watches the toggling doorOpen line driven by the blinker and decodes the high/low phases.
- Counts completed blinks and checks each phase length against a nominal cycle count within a tolerance. Reports done, timing error or timeout to the door/elevator controller.
- Sits between the blinker output and the controller FSM; also serves as a self-check in hardware bring-up.

---
 rtl/blink_mon_pkg.sv | 25 ++
 rtl/sync_edge_det.sv | 85 ++++++++
 rtl/door_blink_monitor.sv | 135 +++++++++++++
 tb/tb_door_blink_monitor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_mon_pkg.sv
// Shared types and helpers for the door blink monitor.
// Optional feature macro used by this block: BLINK_MON_GLITCH_FILTER_EN.
package blink_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_MEASURE,
      ST_DONE,
      ST_ERROR
   } state_e;

   localparam int unsigned CNT_W_DEF = 27;

   // Shortest accepted phase length; clamps at zero for oversized tolerances.
   function automatic int unsigned phase_lo(input int unsigned phase_cyc, input int unsigned tol);
      return (tol >= phase_cyc) ? 32'd0 : phase_cyc - tol;
   endfunction

   // Longest accepted phase length; a phase counter above this is a timeout.
   function automatic int unsigned phase_hi(input int unsigned phase_cyc, input int unsigned tol);
      return phase_cyc + tol;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer plus registered rise/fall pulse generator for an asynchronous
// idle-high line. With BLINK_MON_GLITCH_FILTER_EN defined, a level must be
// stable for FILT_LEN cycles before it is accepted.
module sync_edge_det #(
   parameter int unsigned FILT_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   if (FILT_LEN < 1) begin : g_bad_filt_len
      $error("sync_edge_det: FILT_LEN must be at least 1");
   end

   logic s1_q, s2_q;
   logic prev_q;
   logic rise_q, fall_q;
   logic level;

   // Two-flop synchronizer; resets to the idle-high line level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

`ifdef BLINK_MON_GLITCH_FILTER_EN
   localparam int unsigned FW = $clog2(FILT_LEN + 1);

   logic [FW-1:0] stab_q, stab_d;
   logic          filt_q, filt_d;

   // Accept a new level only after FILT_LEN consecutive disagreeing samples.
   always_comb begin
      stab_d = '0;
      filt_d = filt_q;
      if (s2_q != filt_q) begin
         if (stab_q == FW'(FILT_LEN - 1)) begin
            filt_d = s2_q;
         end else begin
            stab_d = stab_q + FW'(1);
         end
      end
   end

   // Filter state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stab_q <= '0;
         filt_q <= 1'b1;
      end else begin
         stab_q <= stab_d;
         filt_q <= filt_d;
      end
   end

   assign level = filt_q;
`else
   assign level = s2_q;
`endif

   // Registered edge detector on the accepted level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q <= 1'b1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         prev_q <= level;
         rise_q <= level & ~prev_q;
         fall_q <= ~level & prev_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/door_blink_monitor.sv
// Door-open blink checker: counts rising edges of the blinker line and checks
// every phase after the first fall against PHASE_CYC +/- TOL.
// Optional glitch filter in the input path: BLINK_MON_GLITCH_FILTER_EN.
module door_blink_monitor
   import blink_mon_pkg::*;
#(
   parameter int unsigned PHASE_CYC = 50000001,
   parameter int unsigned TOL       = 1000000,
   parameter int unsigned BLINKS    = 3,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned FILT_LEN  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       door_in,
   output logic       busy,
   output logic       done,
   output logic [1:0] blink_cnt,
   output logic       err_timing,
   output logic       err_timeout
);

   localparam logic [CNT_W-1:0] LO_BOUND = CNT_W'(phase_lo(PHASE_CYC, TOL));
   localparam logic [CNT_W-1:0] HI_BOUND = CNT_W'(phase_hi(PHASE_CYC, TOL));
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [1:0]       BLINKS_L = 2'(BLINKS);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       blink_q, blink_d;
   logic             err_timing_q, err_timing_d;
   logic             err_timeout_q, err_timeout_d;

   logic             rise, fall;
   logic [CNT_W-1:0] cnt_inc;
   logic [1:0]       blink_nx;
   logic             phase_ok;
   logic             timed_out;

   sync_edge_det #(
      .FILT_LEN(FILT_LEN)
   ) u_sync_edge_det (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (door_in),
      .rise_o(rise),
      .fall_o(fall)
   );

   assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign blink_nx  = blink_q + 2'd1;
   assign phase_ok  = (cnt_q >= LO_BOUND) && (cnt_q <= HI_BOUND);
   assign timed_out = cnt_q > HI_BOUND;

   // Next-state logic; an edge takes priority over the timeout in the same cycle.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      blink_d       = blink_q;
      err_timing_d  = err_timing_q;
      err_timeout_d = err_timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d       = ST_ARMED;
               cnt_d         = '0;
               blink_d       = '0;
               err_timing_d  = 1'b0;
               err_timeout_d = 1'b0;
            end
         end
         ST_ARMED: begin
            // First phase has unknown alignment to start, so only timeout applies.
            if (fall) begin
               state_d = ST_MEASURE;
               cnt_d   = CNT_W'(1);
            end else if (timed_out) begin
               state_d       = ST_ERROR;
               err_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_MEASURE: begin
            if (rise || fall) begin
               if (!phase_ok) begin
                  state_d      = ST_ERROR;
                  err_timing_d = 1'b1;
               end else begin
                  cnt_d = CNT_W'(1);
                  if (rise) begin
                     blink_d = blink_nx;
                     if (blink_nx == BLINKS_L) begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end else if (timed_out) begin
               state_d       = ST_ERROR;
               err_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ERROR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         blink_q       <= '0;
         err_timing_q  <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         blink_q       <= blink_d;
         err_timing_q  <= err_timing_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign busy        = (state_q == ST_ARMED) || (state_q == ST_MEASURE);
   assign done        = (state_q == ST_DONE);
   assign blink_cnt   = blink_q;
   assign err_timing  = err_timing_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_door_blink_monitor.sv
// Bench for door_blink_monitor with PHASE_CYC=10, TOL=2, BLINKS=3.
// Build with BLINK_MON_GLITCH_FILTER_EN to exercise the glitch filter.
module tb_door_blink_monitor;

   localparam int FL = 4;
`ifdef BLINK_MON_GLITCH_FILTER_EN
   localparam int LAT = 4 + FL;   // drive-after-edge to FSM reaction, in clocks
`else
   localparam int LAT = 4;
`endif

   // ---------------- clock / reset ----------------
   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       start   = 1'b0;
   logic       door_in = 1'b1;
   logic       busy, done, err_timing, err_timeout;
   logic [1:0] blink_cnt;

   always #5 clk = ~clk;

   door_blink_monitor #(
      .PHASE_CYC(10),
      .TOL      (2),
      .BLINKS   (3),
      .CNT_W    (8),
      .FILT_LEN (FL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .door_in    (door_in),
      .busy       (busy),
      .done       (done),
      .blink_cnt  (blink_cnt),
      .err_timing (err_timing),
      .err_timeout(err_timeout)
   );

   // ---------------- scoreboard ----------------
   int         checks    = 0;
   int         errors    = 0;
   int         done_seen = 0;
   logic [1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Every done pulse must match a queued expectation of the final blink count.
   always @(negedge clk) begin
      logic [1:0] e;
      if (rst_n && done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0");
         end else begin
            e = exp_q.pop_front();
            chk("done_blink_cnt", {30'd0, blink_cnt}, {30'd0, e});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int         nph;
      int         len[5];
      int         poke;       // phase index in which start is pulsed, -1 for none
      logic [1:0] exp_blink;
      logic       exp_et;
      logic       exp_eo;
      int         exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input int nph, input int l0, input int l1, input int l2, input int l3,
                          input int l4, input int poke, input logic [1:0] eb, input logic et,
                          input logic eo, input int ed);
      vec_t v;
      v.nph = nph;
      v.len[0] = l0; v.len[1] = l1; v.len[2] = l2; v.len[3] = l3; v.len[4] = l4;
      v.poke = poke;
      v.exp_blink = eb;
      v.exp_et = et;
      v.exp_eo = eo;
      v.exp_done = ed;
      vecs.push_back(v);
   endtask

   // Start, fall, then nph phases each ended by a toggle; then hold the line.
   task automatic run_vec(input vec_t v, input int idx);
      int d0;
      d0 = done_seen;
      if (v.exp_done != 0) exp_q.push_back(v.exp_blink);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk($sformatf("v%0d_busy_armed", idx), busy, 1);
      door_in = 1'b0;
      for (int i = 0; i < v.nph; i++) begin
         for (int c = 0; c < v.len[i]; c++) begin
            start = (i == v.poke && c == 3);
            step(1);
         end
         start = 1'b0;
         door_in = ~door_in;
      end
      step(30);
      chk($sformatf("v%0d_blink_cnt", idx), blink_cnt, v.exp_blink);
      chk($sformatf("v%0d_err_timing", idx), err_timing, v.exp_et);
      chk($sformatf("v%0d_err_timeout", idx), err_timeout, v.exp_eo);
      chk($sformatf("v%0d_busy_end", idx), busy, 0);
      chk($sformatf("v%0d_done_count", idx), done_seen - d0, v.exp_done);
      door_in = 1'b1;
      step(LAT + 2);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_blink"}, blink_cnt, 0);
      chk({tag, "_err_timing"}, err_timing, 0);
      chk({tag, "_err_timeout"}, err_timeout, 0);
   endtask

   // ---------------- test ----------------
   initial begin
      //       nph  l0  l1  l2  l3  l4 poke blink et eo done
      add_vec(5,  10, 10, 10, 10, 10, -1, 2'd3, 0, 0, 1);  // nominal
      add_vec(5,   7, 10, 10, 10, 10, -1, 2'd0, 1, 0, 0);  // short first measured low
      add_vec(0,   0,  0,  0,  0,  0, -1, 2'd0, 0, 1, 0);  // stuck low after first fall
      add_vec(5,   8,  8,  8,  8,  8, -1, 2'd3, 0, 0, 1);  // lower bound accepted
      add_vec(5,  12, 12, 12, 12, 12, -1, 2'd3, 0, 0, 1);  // upper bound accepted
      add_vec(5,   8, 12, 12,  8, 10, -1, 2'd3, 0, 0, 1);  // mixed in-tolerance
      add_vec(5,  10, 13, 10, 10, 10, -1, 2'd1, 1, 0, 0);  // 13: edge coincides with timeout, edge wins
      add_vec(5,  10, 10, 14, 10, 10, -1, 2'd1, 0, 1, 0);  // 14: timeout before the edge
      add_vec(5,  10, 10, 10, 10,  7, -1, 2'd2, 1, 0, 0);  // short last low
      add_vec(2,  10, 10,  0,  0,  0, -1, 2'd1, 0, 1, 0);  // stuck after first blink
      add_vec(5,  10, 10, 10, 10, 10,  2, 2'd3, 0, 0, 1);  // start while busy ignored

      // reset state
      rst_n = 1'b0;
      step(3);
      chk_all_zero("reset");
      rst_n = 1'b1;
      step(2);

      // table-driven scenarios
      for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], k);

      // nominal with exact latency, done timing and start on the DONE cycle
      start = 1'b1; step(1); start = 1'b0;
      door_in = 1'b0; step(10);
      door_in = 1'b1; step(LAT - 1);
      chk("nom_blink_before_edge", blink_cnt, 0);
      step(1);
      chk("nom_blink1", blink_cnt, 1);
      step(10 - LAT);
      door_in = 1'b0; step(10);
      door_in = 1'b1; step(LAT);
      chk("nom_blink2", blink_cnt, 2);
      step(10 - LAT);
      door_in = 1'b0; step(10);
      exp_q.push_back(2'd3);
      door_in = 1'b1; step(LAT - 1);
      chk("nom_done_early", done, 0);
      chk("nom_busy_early", busy, 1);
      step(1);
      chk("nom_done", done, 1);
      chk("nom_busy_with_done", busy, 0);
      chk("nom_blink3", blink_cnt, 3);
      start = 1'b1; step(1); start = 1'b0;
      chk("nom_done_one_cycle", done, 0);
      chk("nom_start_on_done_ignored", busy, 0);
      chk("nom_blink_hold", blink_cnt, 3);
      step(2);
      chk("nom_still_idle", busy, 0);
      chk("nom_no_err", {err_timing, err_timeout}, 0);

      // short phase: error timing, then restart clears it and ARMED times out
      start = 1'b1; step(1); start = 1'b0;
      door_in = 1'b0; step(7);
      door_in = 1'b1; step(LAT - 1);
      chk("short_et_before", err_timing, 0);
      chk("short_busy_before", busy, 1);
      step(1);
      chk("short_et", err_timing, 1);
      chk("short_busy", busy, 0);
      chk("short_blink", blink_cnt, 0);
      step(1);
      chk("short_et_sticky", err_timing, 1);
      start = 1'b1; step(1); start = 1'b0;
      chk("restart_clears_et", err_timing, 0);
      chk("restart_busy", busy, 1);
      step(13);
      chk("armed_eo_before", err_timeout, 0);
      step(1);
      chk("armed_eo", err_timeout, 1);
      chk("armed_eo_busy", busy, 0);
      step(2);

      // stuck low: timeout on the 13th cycle after the fall is seen
      start = 1'b1; step(1); start = 1'b0;
      door_in = 1'b0; step(LAT + 12);
      chk("stuck_eo_before", err_timeout, 0);
      chk("stuck_busy_before", busy, 1);
      step(1);
      chk("stuck_eo", err_timeout, 1);
      chk("stuck_busy", busy, 0);
      chk("stuck_et", err_timing, 0);
      door_in = 1'b1; step(LAT + 2);

      // reset mid-run at blink_cnt=2, then a clean run
      start = 1'b1; step(1); start = 1'b0;
      door_in = 1'b0; step(10);
      door_in = 1'b1; step(10);
      door_in = 1'b0; step(10);
      door_in = 1'b1; step(LAT + 1);
      chk("midrst_blink2", blink_cnt, 2);
      rst_n = 1'b0; step(1);
      chk_all_zero("midrst");
      rst_n = 1'b1; step(2);
      run_vec(vecs[0], 99);

`ifdef BLINK_MON_GLITCH_FILTER_EN
      // 2-cycle low glitch mid-high-phase is filtered out
      start = 1'b1; step(1); start = 1'b0;
      door_in = 1'b0; step(10);
      door_in = 1'b1; step(4);
      door_in = 1'b0; step(2);
      door_in = 1'b1; step(4);
      door_in = 1'b0; step(10);
      door_in = 1'b1; step(10);
      door_in = 1'b0; step(10);
      exp_q.push_back(2'd3);
      door_in = 1'b1; step(LAT);
      chk("glitch_done", done, 1);
      chk("glitch_blink", blink_cnt, 3);
      chk("glitch_no_err", {err_timing, err_timeout}, 0);
      step(3);
`endif

      chk("exp_q_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
